// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit: next-PC source
// encoding, the boot/run state type and the sequential fetch increment.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_BR,
    PC_J,
    PC_JR,
    PC_RAS,
    PC_TRAP,
    PC_ERET,
    PC_HOLD
  } pc_sel_t;

  typedef enum logic {
    BOOT,
    RUN
  } pc_state_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry while count saturates; push and pop together replace the top.
module pc_ras #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            data,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  top_idx;
  logic              pop_ok;

  // ptr is the next free slot; when full it also marks the oldest entry.
  assign top_idx = ptr - 1'b1;
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && pop_ok) begin
      mem[top_idx] <= data;
    end else if (push) begin
      mem[ptr] <= data;
      ptr      <= ptr + 1'b1;
      if (count != FULL_COUNT) count <= count + 1'b1;
    end else if (pop_ok) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot/run FSM, prioritised next-PC selection, branch
// and jump target arithmetic, exception PC and the return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]       TRAP_VECTOR  = 32'h8000_0180,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch_take,
  input  logic [15:0]                branch_imm,
  input  logic                       jump,
  input  logic [25:0]                jump_index,
  input  logic                       jump_reg,
  input  logic [ADDR_W-1:0]          reg_target,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       trap,
  input  logic                       eret,
  output logic [ADDR_W-1:0]          pc,
  output logic [ADDR_W-1:0]          pc_plus4,
  output logic                       pc_valid,
  output logic [ADDR_W-1:0]          epc,
  output logic                       ras_underflow,
  output logic                       fsm_state,
  output logic [$clog2(RAS_DEPTH):0] ras_count
);

  pc_state_t         state;
  pc_sel_t           sel;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic [ADDR_W-1:0] trap_pc;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_push;
  logic              ras_pop;

  assign fsm_state = (state == RUN);

  assign pc_plus4  = pc + ADDR_W'(PC_INC);
  assign br_offset = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign br_target = pc_plus4 + br_offset;
  assign j_target  = {pc_plus4[ADDR_W-1:28], jump_index, 2'b00};
  assign trap_pc   = ADDR_W'(TRAP_VECTOR);

  // Trap outranks stall so an exception is never lost behind a pipeline hold.
  always_comb begin
    sel = PC_SEQ;
    if (state == BOOT)                sel = PC_HOLD;
    else if (trap)                    sel = PC_TRAP;
    else if (stall)                   sel = PC_HOLD;
    else if (eret)                    sel = PC_ERET;
    else if (jump_reg && ret && !ras_empty) sel = PC_RAS;
    else if (jump_reg)                sel = PC_JR;
    else if (jump)                    sel = PC_J;
    else if (branch_take)             sel = PC_BR;
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      PC_BR:   next_pc = br_target;
      PC_J:    next_pc = j_target;
      PC_JR:   next_pc = reg_target;
      PC_RAS:  next_pc = ras_top;
      PC_TRAP: next_pc = trap_pc;
      PC_ERET: next_pc = epc;
      PC_HOLD: next_pc = pc;
      default: next_pc = pc_plus4;
    endcase
  end

  assign ras_push = call && (sel == PC_J || sel == PC_JR || sel == PC_RAS);
  assign ras_pop  = (sel == PC_RAS);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      pc_valid      <= 1'b0;
      epc           <= '0;
      ras_underflow <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state         <= RUN;
          pc_valid      <= 1'b1;
          ras_underflow <= 1'b0;
        end
        default: begin
          pc <= next_pc;
          if (sel == PC_TRAP) epc <= pc;
          // A ret that fell through to the register target found the stack empty.
          ras_underflow <= (sel == PC_JR) && ret;
        end
      endcase
    end
  end

  pc_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .data  (pc_plus4),
    .top   (ras_top),
    .count (ras_count),
    .empty (ras_empty)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: stimulus pushes hand-computed post-edge state
// into a queue; a monitor pops and compares it after every rising edge.
module tb_pc_unit;

  localparam int W = 102;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, branch_take, jump, jump_reg, call, ret, trap, eret;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] reg_target;
  logic [31:0] pc, pc_plus4, epc;
  logic        pc_valid, ras_underflow, fsm_state;
  logic [2:0]  ras_count;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [31:0]  exp_epc;
  int           n_vec  = 0;
  int           n_fail = 0;

  pc_unit #(
    .ADDR_W       (32),
    .RESET_VECTOR (32'h0),
    .TRAP_VECTOR  (32'h8000_0180),
    .RAS_DEPTH    (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .branch_take   (branch_take),
    .branch_imm    (branch_imm),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .call          (call),
    .ret           (ret),
    .trap          (trap),
    .eret          (eret),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .pc_valid      (pc_valid),
    .epc           (epc),
    .ras_underflow (ras_underflow),
    .fsm_state     (fsm_state),
    .ras_count     (ras_count)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic clear_ctl();
    stall = 0; branch_take = 0; jump = 0; jump_reg = 0;
    call = 0; ret = 0; trap = 0; eret = 0;
    branch_imm = '0; jump_index = '0; reg_target = '0;
  endtask

  // Expected state right after the coming rising edge.
  task automatic step(input string nm, input logic [31:0] p, input logic v,
                      input logic uf, input logic st, input logic [2:0] cnt);
    logic [31:0] p4;
    p4 = p + 32'd4;
    exp_q.push_back({st, v, uf, cnt, exp_epc, p4, p});
    name_q.push_back(nm);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_jr(input logic [31:0] t, input logic r, input logic c);
    clear_ctl(); jump_reg = 1; reg_target = t; ret = r; call = c;
  endtask

  task automatic do_jal(input logic [25:0] idx);
    clear_ctl(); jump = 1; call = 1; jump_index = idx;
  endtask

  // scoreboard monitor
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {fsm_state, pc_valid, ras_underflow, ras_count, epc, pc_plus4, pc};
      n_vec++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%b v=%b uf=%b cnt=%0d epc=%h pc4=%h pc=%h, need st=%b v=%b uf=%b cnt=%0d epc=%h pc4=%h pc=%h",
                 nm, a[101], a[100], a[99], a[98:96], a[95:64], a[63:32], a[31:0],
                 e[101], e[100], e[99], e[98:96], e[95:64], e[63:32], e[31:0]);
      end
    end
  end

  initial begin
    exp_epc = 32'h0;
    clear_ctl();
    reset = 0;
    @(negedge clock);

    step("reset", 32'h0, 0, 0, 0, 3'd0);
    reset = 1; trap = 1; jump = 1; call = 1; jump_index = 26'h10;
    step("boot_ignores", 32'h0, 1, 0, 1, 3'd0);
    clear_ctl();
    step("seq4", 32'h4, 1, 0, 1, 3'd0);
    step("seq8", 32'h8, 1, 0, 1, 3'd0);

    do_jr(32'h100, 0, 0);
    step("jr_100", 32'h100, 1, 0, 1, 3'd0);
    clear_ctl(); branch_take = 1; branch_imm = 16'hFFFF;
    step("br_back", 32'h100, 1, 0, 1, 3'd0);
    branch_imm = 16'h0003;
    step("br_fwd", 32'h110, 1, 0, 1, 3'd0);

    do_jr(32'h0040_0000, 0, 0);
    step("jr_400000", 32'h0040_0000, 1, 0, 1, 3'd0);
    do_jal(26'h10);
    step("jal", 32'h40, 1, 0, 1, 3'd1);
    do_jr(32'hDEAD, 1, 0);
    step("ret", 32'h0040_0004, 1, 0, 1, 3'd0);
    do_jr(32'h300, 1, 0);
    step("ret_empty", 32'h300, 1, 1, 1, 3'd0);
    clear_ctl();
    step("uf_pulse_end", 32'h304, 1, 0, 1, 3'd0);

    // five calls into a four-deep stack; the first return address is lost
    do_jal(26'h100); step("call_a", 32'h400,  1, 0, 1, 3'd1);
    do_jal(26'h200); step("call_b", 32'h800,  1, 0, 1, 3'd2);
    do_jal(26'h300); step("call_c", 32'hC00,  1, 0, 1, 3'd3);
    do_jal(26'h400); step("call_d", 32'h1000, 1, 0, 1, 3'd4);
    do_jal(26'h500); step("call_e", 32'h1400, 1, 0, 1, 3'd4);
    do_jr(32'h7000, 1, 0);
    step("pop_e", 32'h1004, 1, 0, 1, 3'd3);
    step("pop_d", 32'hC04,  1, 0, 1, 3'd2);
    step("pop_c", 32'h804,  1, 0, 1, 3'd1);
    step("pop_b", 32'h404,  1, 0, 1, 3'd0);
    step("pop_under", 32'h7000, 1, 1, 1, 3'd0);
    clear_ctl();
    step("after_under", 32'h7004, 1, 0, 1, 3'd0);

    // call with ret replaces the top entry
    do_jal(26'h100); step("call_f", 32'h400, 1, 0, 1, 3'd1);
    do_jr(32'h5555, 1, 1);
    step("ret_call", 32'h7008, 1, 0, 1, 3'd1);
    do_jr(32'h6000, 1, 0);
    step("ret_replaced", 32'h404, 1, 0, 1, 3'd0);

    do_jr(32'h200, 0, 0);
    step("jr_200", 32'h200, 1, 0, 1, 3'd0);
    clear_ctl(); stall = 1; trap = 1;
    exp_epc = 32'h200;
    step("stall_trap", 32'h8000_0180, 1, 0, 1, 3'd0);
    clear_ctl(); eret = 1;
    step("eret", 32'h200, 1, 0, 1, 3'd0);
    do_jal(26'h80);
    step("jal_self", 32'h200, 1, 0, 1, 3'd1);
    stall = 1; jump_index = 26'h40;
    for (int i = 0; i < 3; i++) step("stall_jump", 32'h200, 1, 0, 1, 3'd1);
    do_jr(32'h900, 1, 0);
    step("ret_after_stall", 32'h204, 1, 0, 1, 3'd0);
    clear_ctl();
    step("seq_208", 32'h208, 1, 0, 1, 3'd0);

    do_jal(26'h10);
    step("jal_pre_reset", 32'h40, 1, 0, 1, 3'd1);
    reset = 0; jump_index = 26'h20;
    exp_epc = 32'h0;
    step("reset_mid_call", 32'h0, 0, 0, 0, 3'd0);
    reset = 1; clear_ctl();
    step("reboot", 32'h0, 1, 0, 1, 3'd0);
    do_jr(32'hA00, 1, 0);
    step("ras_cleared", 32'hA00, 1, 1, 1, 3'd0);
    clear_ctl();
    step("final_seq", 32'hA04, 1, 0, 1, 3'd0);

    @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
